// File: rtl/audio_pkg.sv
// audio_pkg: shared widths, FSM state type and sample type for the audio I2S path
package audio_pkg;
   localparam int AUDIO_DATA_W   = 16;
   localparam int AUDIO_SLOT_W   = 32;
   localparam int AUDIO_BCLK_DIV = 4;
   typedef enum logic {I2S_IDLE, I2S_RUN} i2s_state_t;
   typedef logic signed [AUDIO_DATA_W-1:0] audio_sample_t;
endpackage

// File: rtl/i2s_clkgen.sv
// i2s_clkgen: BCLK phase and bit-position counters for the I2S frame
//   clk, rst        audio clock, sync active-high reset
//   i_active        FSM is in RUN
//   i_en            counters advance (RUN and staying in RUN); else held at 0
//   o_bclk_cnt      phase within one BCLK period
//   o_bit_cnt       BCLK position within the stereo frame
//   o_bit_nxt       bit position that follows the next falling edge
//   o_fe            last phase of the BCLK period (falling edge next)
//   o_frame_start   first cycle of a frame
module i2s_clkgen
   import audio_pkg::*;
#(
   parameter int SLOT_W   = AUDIO_SLOT_W,
   parameter int BCLK_DIV = AUDIO_BCLK_DIV
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          i_active,
   input  logic                          i_en,
   output logic [$clog2(BCLK_DIV)-1:0]   o_bclk_cnt,
   output logic [$clog2(2*SLOT_W)-1:0]   o_bit_cnt,
   output logic [$clog2(2*SLOT_W)-1:0]   o_bit_nxt,
   output logic                          o_fe,
   output logic                          o_frame_start
);
   localparam int CW = $clog2(BCLK_DIV);
   localparam int BW = $clog2(2*SLOT_W);
   logic [CW-1:0] r_bclk_cnt;
   logic [BW-1:0] r_bit_cnt;
   assign o_bclk_cnt    = r_bclk_cnt;
   assign o_bit_cnt     = r_bit_cnt;
   assign o_fe          = r_bclk_cnt == CW'(BCLK_DIV-1);
   assign o_bit_nxt     = (r_bit_cnt == BW'(2*SLOT_W-1)) ? '0 : r_bit_cnt + 1'b1;
   assign o_frame_start = i_active && r_bclk_cnt == '0 && r_bit_cnt == '0;
   always_ff @(posedge clk) begin
      if (rst || !i_en) begin
         r_bclk_cnt <= '0;
         r_bit_cnt  <= '0;
      end else begin
         r_bclk_cnt <= o_fe ? '0 : r_bclk_cnt + 1'b1;
         if (o_fe) r_bit_cnt <= o_bit_nxt;
      end
   end
endmodule

// File: rtl/audio_i2s_tx.sv
// audio_i2s_tx: I2S transmitter with lock-gated start, sample holding register and underrun flag
//   clk, rst                      audio clock, sync active-high reset
//   pll_locked                    PLL lock, synchronous to clk
//   sample_left/right/valid       stereo sample pair input; sample_ready = holding register empty
//   i2s_bclk/lrck/sdata           codec serial interface (left-justified one BCLK after LRCK)
//   underrun                      1-cycle pulse when a frame starts with nothing new to send
module audio_i2s_tx
   import audio_pkg::*;
#(
   parameter int DATA_W    = AUDIO_DATA_W,
   parameter int SLOT_W    = AUDIO_SLOT_W,
   parameter int BCLK_DIV  = AUDIO_BCLK_DIV,
   parameter int LOCK_WAIT = 1024
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     pll_locked,
   input  logic signed [DATA_W-1:0] sample_left,
   input  logic signed [DATA_W-1:0] sample_right,
   input  logic                     sample_valid,
   output logic                     sample_ready,
   output logic                     i2s_bclk,
   output logic                     i2s_lrck,
   output logic                     i2s_sdata,
   output logic                     underrun
);
   localparam int CW = $clog2(BCLK_DIV);
   localparam int BW = $clog2(2*SLOT_W);
   localparam int LW = $clog2(LOCK_WAIT+1);
   i2s_state_t        r_state, w_state_nxt;
   logic [LW-1:0]     r_lock_cnt;
   logic [CW-1:0]     w_bclk_cnt;
   logic [BW-1:0]     w_bit_cnt, w_bit_nxt, w_k;
   logic              w_fe, w_frame_start, w_lock_done, w_go, w_acc, w_hold_nxt;
   logic              w_lrck_nxt, w_sdata_nxt;
   logic [DATA_W-1:0] w_word, w_shift;
   logic [DATA_W-1:0] r_hold_left, r_hold_right, r_left, r_right;
   logic              r_hold_full, r_seen, r_ready, r_bclk, r_lrck, r_sdata, r_underrun;
   i2s_clkgen #(.SLOT_W(SLOT_W), .BCLK_DIV(BCLK_DIV)) u_clkgen (
      .clk          (clk),
      .rst          (rst),
      .i_active     (r_state == I2S_RUN),
      .i_en         (w_go),
      .o_bclk_cnt   (w_bclk_cnt),
      .o_bit_cnt    (w_bit_cnt),
      .o_bit_nxt    (w_bit_nxt),
      .o_fe         (w_fe),
      .o_frame_start(w_frame_start)
   );
   assign w_lock_done = pll_locked && r_lock_cnt == LW'(LOCK_WAIT-1);
   always_comb begin
      w_state_nxt = r_state;
      w_go        = 1'b0;
      if (r_state == I2S_IDLE) begin
         if (w_lock_done) w_state_nxt = I2S_RUN;
      end else if (!pll_locked) w_state_nxt = I2S_IDLE;
      else w_go = 1'b1;
   end
   always_ff @(posedge clk) begin
      if (rst) r_state <= I2S_IDLE;
      else r_state <= w_state_nxt;
   end
   assign w_acc      = sample_valid && r_ready;
   // the frame load sees the pre-accept holding register, so a same-cycle accept waits a frame
   assign w_hold_nxt = w_acc || (r_hold_full && !w_frame_start);
   // select the bit that goes out after the coming BCLK falling edge; bit 0 of each slot is the I2S delay
   assign w_lrck_nxt  = w_bit_nxt >= BW'(SLOT_W);
   assign w_k         = w_lrck_nxt ? w_bit_nxt - BW'(SLOT_W) : w_bit_nxt;
   assign w_word      = w_lrck_nxt ? r_right : r_left;
   assign w_shift     = w_word << (w_k - 1'b1);
   assign w_sdata_nxt = w_k != '0 && w_k <= BW'(DATA_W) && w_shift[DATA_W-1];
   always_ff @(posedge clk) begin
      if (rst || !w_go) begin
         r_lock_cnt   <= (!rst && r_state == I2S_IDLE && pll_locked && !w_lock_done) ? r_lock_cnt + 1'b1 : '0;
         r_ready      <= !rst && w_state_nxt == I2S_RUN;
         r_hold_left  <= '0;
         r_hold_right <= '0;
         r_left       <= '0;
         r_right      <= '0;
         r_hold_full  <= 1'b0;
         r_seen       <= 1'b0;
         r_bclk       <= 1'b0;
         r_lrck       <= 1'b0;
         r_sdata      <= 1'b0;
         r_underrun   <= 1'b0;
      end else begin
         r_lock_cnt <= '0;
         r_bclk     <= (w_bclk_cnt == CW'(BCLK_DIV/2-1)) ? 1'b1 : (w_fe ? 1'b0 : r_bclk);
         if (w_fe) begin
            r_lrck  <= w_lrck_nxt;
            r_sdata <= w_sdata_nxt;
         end
         r_underrun <= w_frame_start && !r_hold_full && r_seen;
         if (w_frame_start && r_hold_full) begin
            r_left  <= r_hold_left;
            r_right <= r_hold_right;
         end
         if (w_acc) begin
            r_hold_left  <= sample_left;
            r_hold_right <= sample_right;
            r_seen       <= 1'b1;
         end
         r_hold_full <= w_hold_nxt;
         r_ready     <= !w_hold_nxt;
      end
   end
   assign sample_ready = r_ready;
   assign i2s_bclk     = r_bclk;
   assign i2s_lrck     = r_lrck;
   assign i2s_sdata    = r_sdata;
   assign underrun     = r_underrun;
endmodule

// File: tb/tb_audio_i2s_tx.sv
// tb_audio_i2s_tx: directed stimulus with a cycle-time model of the I2S frame and literal spot checks
module tb_audio_i2s_tx;
   localparam int LW = 8;
   logic        clk = 1'b0, rst = 1'b1, pll_locked = 1'b0, sample_valid = 1'b0;
   logic [15:0] sample_left = '0, sample_right = '0;
   logic        sample_ready, i2s_bclk, i2s_lrck, i2s_sdata, underrun;
   int          n_chk = 0, n_pass = 0, cyc = 0, last_rise = 0, lrck_gap = 0;
   bit          chk_en = 1'b0, prev_lrck = 1'b0;
   bit          m_run, m_hf, m_seen, m_und;
   int          m_t, m_lock;
   logic [15:0] m_hl, m_hr, m_fl, m_fr;
   logic [15:0] cl, cr;
   int          z, u, r_low;

   always #5 clk = ~clk;

   audio_i2s_tx #(.LOCK_WAIT(LW)) dut (
      .clk(clk), .rst(rst), .pll_locked(pll_locked),
      .sample_left(sample_left), .sample_right(sample_right), .sample_valid(sample_valid),
      .sample_ready(sample_ready), .i2s_bclk(i2s_bclk), .i2s_lrck(i2s_lrck),
      .i2s_sdata(i2s_sdata), .underrun(underrun)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
   endtask

   task automatic m_clear();
      m_run = 0; m_hf = 0; m_seen = 0; m_und = 0; m_t = 0; m_lock = 0;
      m_hl = '0; m_hr = '0; m_fl = '0; m_fr = '0;
   endtask

   // Model: time t since RUN entry fixes the bit position; frames are 256 cycles, 64 BCLKs of 4 cycles.
   always @(posedge clk) begin
      bit acc, un;
      cyc++;
      if (rst) m_clear();
      else if (!m_run) begin
         m_und = 0;
         if (!pll_locked) m_lock = 0;
         else if (m_lock == LW-1) begin m_run = 1; m_t = 0; m_lock = 0; end
         else m_lock++;
      end else if (!pll_locked) m_clear();
      else begin
         acc = sample_valid && !m_hf;
         un  = 0;
         if (m_t % 256 == 0) begin
            if (m_hf) begin m_fl = m_hl; m_fr = m_hr; m_hf = 0; end
            else un = m_seen;
         end
         if (acc) begin m_hl = sample_left; m_hr = sample_right; m_hf = 1; m_seen = 1; end
         m_t++;
         m_und = un;
      end
   end

   function automatic logic exp_sdata();
      int b = (m_t / 4) % 64;
      int k = b % 32;
      logic [15:0] w = (b >= 32) ? m_fr : m_fl;
      return m_run && k >= 1 && k <= 16 && w[16-k];
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         check("bclk",     i2s_bclk,     m_run && (m_t % 4) >= 2);
         check("lrck",     i2s_lrck,     m_run && ((m_t / 4) % 64) >= 32);
         check("sdata",    i2s_sdata,    exp_sdata());
         check("ready",    sample_ready, m_run && !m_hf);
         check("underrun", underrun,     m_und);
      end
      if (i2s_lrck && !prev_lrck) begin lrck_gap = cyc - last_rise; last_rise = cyc; end
      prev_lrck = i2s_lrck;
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic capture(output logic [15:0] l, output logic [15:0] r, output int zs, output int us);
      l = '0; r = '0; zs = 0; us = 0;
      for (int i = 0; i < 256; i++) begin
         int b;
         b = i / 4;
         if (underrun) us++;
         if (i % 4 == 0) begin
            if (b >= 1 && b <= 16) l = {l[14:0], i2s_sdata};
            else if (b >= 33 && b <= 48) r = {r[14:0], i2s_sdata};
            else zs += int'(i2s_sdata);
         end
         step(1);
      end
   endtask

   initial begin
      step(3);
      chk_en = 1'b1;
      // lock timer: RUN on the 8th locked cycle, BCLK rises two cycles later
      rst = 1'b0; pll_locked = 1'b1;
      step(7);  check("t1_idle_ready", sample_ready, 0); check("t1_idle_bclk", i2s_bclk, 0);
      step(1);  check("t1_run_ready", sample_ready, 1); check("t1_run_bclk", i2s_bclk, 0);
      step(1);  check("t1_bclk_c9", i2s_bclk, 0);
      step(1);  check("t1_bclk_rise", i2s_bclk, 1);
      // lock glitch at lock_cnt=5 restarts the count
      rst = 1'b1; step(2); rst = 1'b0;
      step(5); pll_locked = 1'b0;
      step(1); pll_locked = 1'b1;
      step(7); check("t2_wait", sample_ready, 0);
      step(1); check("t2_run", sample_ready, 1);
      // one pair accepted before the next frame start
      step(1); sample_left = 16'hA5C3; sample_right = 16'h8001; sample_valid = 1'b1;
      step(1); sample_valid = 1'b0;
      check("t3_ready_drop", sample_ready, 0);
      step(254);
      capture(cl, cr, z, u);
      check("t3_left", cl, 16'hA5C3); check("t3_right", cr, 16'h8001);
      check("t3_zero_bits", z, 0); check("t3_no_underrun", u, 0);
      check("t3_lrck_period", lrck_gap, 256);
      // no more samples: two repeated frames, one underrun each, ready stays high
      u = 0; r_low = 0;
      repeat (512) begin
         if (underrun) u++;
         if (!sample_ready) r_low++;
         step(1);
      end
      check("t4_underruns", u, 2); check("t4_ready_low", r_low, 0);
      // accept in the frame-load cycle: old pair repeats, new pair one frame later
      sample_left = 16'h1234; sample_right = 16'hFEDC; sample_valid = 1'b1;
      step(1); sample_valid = 1'b0;
      check("t5_underrun", underrun, 1); check("t5_ready", sample_ready, 0);
      step(255);
      capture(cl, cr, z, u);
      check("t5_left", cl, 16'h1234); check("t5_right", cr, 16'hFEDC);
      check("t5_zero_bits", z, 0); check("t5_no_underrun", u, 0);
      // lock loss in the right slot while BCLK is high
      step(162);
      check("t6_pre_bclk", i2s_bclk, 1); check("t6_pre_lrck", i2s_lrck, 1);
      pll_locked = 1'b0;
      step(1);
      check("t6_quiet", {i2s_bclk, i2s_lrck, i2s_sdata, sample_ready}, 0);
      step(2); pll_locked = 1'b1;
      step(8); check("t6_relock", sample_ready, 1);
      capture(cl, cr, z, u);
      check("t6_left", cl, 0); check("t6_right", cr, 0); check("t6_no_underrun", u, 0);
      step(2); check("t6_no_underrun2", underrun, 0);
      // reset mid-frame truncates immediately
      step(100); rst = 1'b1;
      step(1);
      check("rst_mid", {i2s_bclk, i2s_lrck, i2s_sdata, sample_ready, underrun}, 0);
      rst = 1'b0; pll_locked = 1'b0;
      step(3);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
